// File: rtl/sdram_arb_pkg.sv
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and default constants for the SDRAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_arb_pkg;

  // Default geometry and policy constants
  localparam int ARB_AW         = 24;
  localparam int ARB_DW         = 16;
  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_TIMEOUT    = 64;

  // Which requester currently owns the SDRAM port
  typedef enum logic [1:0] {
    OWN_DL  = 2'd0,
    OWN_VID = 2'd1,
    OWN_CPU = 2'd2
  } owner_t;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sdram_arb_if.sv
// ============================================================================
// Module      : sdram_arb_if
// Description : Requester handshakes plus the SDRAM controller command port.
//               slave = arbiter view, master = requesters/controller view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sdram_arb_if #(
  parameter int AW = 24,
  parameter int DW = 16
);

  // download requester
  logic          dl_req;
  logic          dl_ack;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_din;
  // video requester
  logic          vid_req;
  logic          vid_ack;
  logic [AW-1:0] vid_addr;
  // CPU requester
  logic          cpu_req;
  logic          cpu_ack;
  logic          cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_din;
  // shared read data back to requesters
  logic [DW-1:0] rdata;
  // SDRAM controller command port
  logic          mem_req;
  logic          mem_we;
  logic [1:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_ack;
  logic [DW-1:0] mem_dout;

  modport slave (
    input  dl_req, dl_addr, dl_din,
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_din,
    output dl_ack, vid_ack, cpu_ack, rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_din,
    input  mem_ack, mem_dout
  );

  modport master (
    output dl_req, dl_addr, dl_din,
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_din,
    input  dl_ack, vid_ack, cpu_ack, rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_din,
    output mem_ack, mem_dout
  );

endinterface

`default_nettype wire

// File: rtl/sdram_arb_prio.sv
// ============================================================================
// Module      : sdram_arb_prio
// Description : Fixed-priority winner select (dl > vid > cpu) with a CPU
//               starvation guard that lets the CPU overtake video after
//               STARVE_MAX consecutive video grants.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_arb_prio
  import sdram_arb_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX
) (
  input  wire    clk_sys,
  input  wire    rst_n,
  input  wire    i_en,        // arbiter is in IDLE and may grant
  input  wire    i_dl_req,
  input  wire    i_vid_req,
  input  wire    i_cpu_req,
  output owner_t o_winner,
  output logic   o_valid,
  output logic   o_grant      // a grant is taken this cycle; updates the counter
);

  localparam int SCW = $clog2(STARVE_MAX + 1);

  logic [SCW-1:0] r_starve;
  logic           w_cpu_first;

  assign w_cpu_first = i_cpu_req && (r_starve == SCW'(STARVE_MAX));
  assign o_valid     = i_dl_req || i_vid_req || i_cpu_req;
  assign o_grant     = i_en && o_valid;

  // Winner select: download always first, then starved CPU, then video, then CPU
  always_comb begin
    o_winner = OWN_DL;
    if (i_dl_req)
      o_winner = OWN_DL;
    else if (w_cpu_first)
      o_winner = OWN_CPU;
    else if (i_vid_req)
      o_winner = OWN_VID;
    else if (i_cpu_req)
      o_winner = OWN_CPU;
  end

  // Count video grants that bypassed a waiting CPU; clear once the CPU is served or idle
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      r_starve <= '0;
    else if (o_grant && (o_winner == OWN_CPU))
      r_starve <= '0;
    else if (i_en && !i_cpu_req)
      r_starve <= '0;
    else if (o_grant && (o_winner == OWN_VID) && i_cpu_req && (r_starve != SCW'(STARVE_MAX)))
      r_starve <= r_starve + 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
// ============================================================================
// Module      : sdram_port_arbiter
// Description : Shares one SDRAM controller port between download, video and
//               CPU requesters. One transaction at a time, registered command,
//               1-cycle ack pulses, per-transaction timeout with sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  wire         clk_sys,
  input  wire         rst_n,
  sdram_arb_if.slave  bus,
  output logic        timeout_err
);

  localparam int TCW = $clog2(TIMEOUT + 1);

  state_t         r_state;
  state_t         w_state_nxt;
  owner_t         r_owner;
  owner_t         w_winner;
  logic           w_valid;
  logic           w_grant;
  logic           w_done;
  logic           w_abort;

  logic           r_mem_req;
  logic           r_mem_we;
  logic [1:0]     r_mem_be;
  logic [AW-1:0]  r_mem_addr;
  logic [DW-1:0]  r_mem_din;
  logic [DW-1:0]  r_rdata;
  logic           r_dl_ack;
  logic           r_vid_ack;
  logic           r_cpu_ack;
  logic           r_timeout_err;
  logic [TCW-1:0] r_tcnt;

  sdram_arb_prio #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .i_en      (r_state == IDLE),
    .i_dl_req  (bus.dl_req),
    .i_vid_req (bus.vid_req),
    .i_cpu_req (bus.cpu_req),
    .o_winner  (w_winner),
    .o_valid   (w_valid),
    .o_grant   (w_grant)
  );

  // FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // FSM next-state: grant from IDLE, finish or abort from BUSY, one GAP cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_valid) w_state_nxt = BUSY;
      BUSY:    if (w_done || w_abort) w_state_nxt = GAP;
      GAP:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: completion wins over a timeout landing in the same cycle.
  // r_tcnt is 0 in the first BUSY cycle, so the abort ack lands TIMEOUT+1
  // cycles after mem_req rises.
  always_comb begin
    w_done  = (r_state == BUSY) && bus.mem_ack;
    w_abort = (r_state == BUSY) && !bus.mem_ack && (r_tcnt == TCW'(TIMEOUT));
  end

  // Cycles spent in BUSY for the current transaction
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)
      r_tcnt <= '0;
    else if (r_state != BUSY)
      r_tcnt <= '0;
    else
      r_tcnt <= r_tcnt + 1'b1;
  end

  // Command latch on grant, completion/abort handling, ack pulses and sticky error
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_owner       <= OWN_DL;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_be      <= 2'b00;
      r_mem_addr    <= '0;
      r_mem_din     <= '0;
      r_rdata       <= '0;
      r_dl_ack      <= 1'b0;
      r_vid_ack     <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_dl_ack  <= 1'b0;
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      if (w_grant) begin
        r_owner   <= w_winner;
        r_mem_req <= 1'b1;
        case (w_winner)
          OWN_DL: begin
            r_mem_we   <= 1'b1;
            r_mem_be   <= 2'b11;
            r_mem_addr <= bus.dl_addr;
            r_mem_din  <= bus.dl_din;
          end
          OWN_VID: begin
            r_mem_we   <= 1'b0;
            r_mem_be   <= 2'b11;
            r_mem_addr <= bus.vid_addr;
            r_mem_din  <= '0;
          end
          default: begin
            r_mem_we   <= bus.cpu_we;
            r_mem_be   <= bus.cpu_be;
            r_mem_addr <= bus.cpu_addr;
            r_mem_din  <= bus.cpu_din;
          end
        endcase
      end
      if (w_done || w_abort) begin
        r_mem_req <= 1'b0;
        r_rdata   <= w_done ? bus.mem_dout : '0;
        case (r_owner)
          OWN_DL:  r_dl_ack  <= 1'b1;
          OWN_VID: r_vid_ack <= 1'b1;
          default: r_cpu_ack <= 1'b1;
        endcase
        if (w_abort)
          r_timeout_err <= 1'b1;
      end
    end
  end

  assign bus.mem_req  = r_mem_req;
  assign bus.mem_we   = r_mem_we;
  assign bus.mem_be   = r_mem_be;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_din  = r_mem_din;
  assign bus.rdata    = r_rdata;
  assign bus.dl_ack   = r_dl_ack;
  assign bus.vid_ack  = r_vid_ack;
  assign bus.cpu_ack  = r_cpu_ack;
  assign timeout_err  = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
// ============================================================================
// Module      : tb_sdram_port_arbiter
// Description : Self-checking bench for sdram_port_arbiter. Expected acks
//               (which requester, which rdata) are queued as stimulus is
//               driven and popped by a monitor whenever an ack fires.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  localparam logic [2:0] c_ACK_DL  = 3'b001;
  localparam logic [2:0] c_ACK_VID = 3'b010;
  localparam logic [2:0] c_ACK_CPU = 3'b100;

  typedef struct {
    logic [2:0]  vec;
    logic [15:0] data;
  } exp_t;

  logic clk_sys;
  logic rst_n;
  logic timeout_err;
  int   n_total;
  int   n_bad;
  exp_t sb[$];

  sdram_arb_if #(.AW(24), .DW(16)) bus ();

  sdram_port_arbiter #(
    .AW(24), .DW(16), .STARVE_MAX(4), .TIMEOUT(64)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .bus         (bus),
    .timeout_err (timeout_err)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Compare one observed value against its expectation
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [2:0] v, input logic [15:0] d);
    exp_t e;
    e.vec  = v;
    e.data = d;
    sb.push_back(e);
  endtask

  // Wait (bounded) for mem_req; n returns the number of cycles taken
  task automatic wait_mem_req(output int n);
    n = 0;
    while (!bus.mem_req && n < 200) begin
      tick();
      n++;
    end
    if (!bus.mem_req)
      chk("memreq_wait", 32'd0, 32'd1);
  endtask

  // Controller model: mem_ack after lat cycles with read data d
  task automatic serve(input int lat, input logic [15:0] d);
    repeat (lat) tick();
    bus.mem_ack  = 1'b1;
    bus.mem_dout = d;
    tick();
    bus.mem_ack  = 1'b0;
    bus.mem_dout = '0;
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_mem_req"},  {31'd0, bus.mem_req},  32'd0);
    chk({tag, "_mem_we"},   {31'd0, bus.mem_we},   32'd0);
    chk({tag, "_mem_be"},   {30'd0, bus.mem_be},   32'd0);
    chk({tag, "_mem_addr"}, {8'd0, bus.mem_addr},  32'd0);
    chk({tag, "_mem_din"},  {16'd0, bus.mem_din},  32'd0);
    chk({tag, "_rdata"},    {16'd0, bus.rdata},    32'd0);
    chk({tag, "_acks"},     {29'd0, bus.cpu_ack, bus.vid_ack, bus.dl_ack}, 32'd0);
    chk({tag, "_err"},      {31'd0, timeout_err},  32'd0);
  endtask

  // Scoreboard monitor: every ack must match the next queued expectation
  always @(posedge clk_sys) begin
    logic [2:0] v;
    exp_t       e;
    #1;
    v = {bus.cpu_ack, bus.vid_ack, bus.dl_ack};
    if (v != 3'b000) begin
      if (sb.size() == 0) begin
        chk("unexp_ack", {29'd0, v}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_owner", {29'd0, v}, {29'd0, e.vec});
        chk("ack_rdata", {16'd0, bus.rdata}, {16'd0, e.data});
      end
    end
  end

  // Absolute time limit
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic early;
    logic [23:0] st_addr [6];
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    bus.dl_req = 0; bus.dl_addr = '0; bus.dl_din = '0;
    bus.vid_req = 0; bus.vid_addr = '0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_be = 2'b00; bus.cpu_addr = '0; bus.cpu_din = '0;
    bus.mem_ack = 0; bus.mem_dout = '0;

    // reset state
    tick(); tick();
    rst_checks("rst0");
    rst_n = 1'b1;
    tick();

    // single CPU write
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_be = 2'b01;
    bus.cpu_addr = 24'h000123; bus.cpu_din = 16'hBEEF;
    push(c_ACK_CPU, 16'h5A5A);
    wait_mem_req(n);
    chk("cpu_lat", n, 1);
    chk("cpu_we",   {31'd0, bus.mem_we},  32'd1);
    chk("cpu_be",   {30'd0, bus.mem_be},  32'd1);
    chk("cpu_addr", {8'd0, bus.mem_addr}, 32'h000123);
    chk("cpu_din",  {16'd0, bus.mem_din}, 32'h0000BEEF);
    bus.cpu_req = 0;
    bus.cpu_addr = 24'hFFFFFF; bus.cpu_din = 16'h0000;
    repeat (3) tick();
    chk("busy_hold_addr", {8'd0, bus.mem_addr}, 32'h000123);
    serve(1, 16'h5A5A);
    chk("cpu_ack", {31'd0, bus.cpu_ack}, 32'd1);
    chk("cpu_done_memreq", {31'd0, bus.mem_req}, 32'd0);
    tick(); tick();

    // simultaneous requests: dl, then vid, then cpu
    bus.dl_req = 1;  bus.dl_addr = 24'h000010; bus.dl_din = 16'hD1D1;
    bus.vid_req = 1; bus.vid_addr = 24'h000020;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_be = 2'b11; bus.cpu_addr = 24'h000030;
    push(c_ACK_DL, 16'h1111);
    push(c_ACK_VID, 16'h1111);
    push(c_ACK_CPU, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      wait_mem_req(n);
      chk("sim_lat", n, (i == 0) ? 1 : 2);
      chk("sim_addr", {8'd0, bus.mem_addr}, 32'h000010 + 32'(i) * 32'h10);
      if (i == 0) chk("dl_din", {16'd0, bus.mem_din}, 32'h0000D1D1);
      if (i == 1) chk("vid_we", {31'd0, bus.mem_we}, 32'd0);
      serve(2, 16'h1111);
      if (i == 0) bus.dl_req = 0;
      if (i == 1) bus.vid_req = 0;
      if (i == 2) bus.cpu_req = 0;
    end
    tick(); tick();

    // starvation guard: four video grants, then CPU, then video again
    for (int i = 0; i < 6; i++) st_addr[i] = (i == 4) ? 24'h000300 : 24'h000200;
    bus.vid_req = 1; bus.vid_addr = 24'h000200;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_be = 2'b11; bus.cpu_addr = 24'h000300;
    for (int i = 0; i < 6; i++)
      push((i == 4) ? c_ACK_CPU : c_ACK_VID, 16'h2000 + 16'(i));
    for (int i = 0; i < 6; i++) begin
      wait_mem_req(n);
      chk("starve_addr", {8'd0, bus.mem_addr}, {8'd0, st_addr[i]});
      serve(1, 16'h2000 + 16'(i));
      if (i == 4) bus.cpu_req = 0;
      if (i == 5) bus.vid_req = 0;
    end
    tick(); tick();

    // timeout: controller never answers
    bus.vid_req = 1; bus.vid_addr = 24'h000ABC;
    push(c_ACK_VID, 16'h0000);
    wait_mem_req(n);
    bus.vid_req = 0;
    bus.mem_dout = 16'hDEAD;
    early = 1'b0;
    repeat (64) begin
      tick();
      if (bus.vid_ack) early = 1'b1;
    end
    chk("to_early", {31'd0, early}, 32'd0);
    tick();
    chk("to_ack", {31'd0, bus.vid_ack}, 32'd1);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_memreq", {31'd0, bus.mem_req}, 32'd0);
    bus.mem_dout = '0;
    tick(); tick();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_be = 2'b11; bus.cpu_addr = 24'h000444;
    push(c_ACK_CPU, 16'h4242);
    wait_mem_req(n);
    bus.cpu_req = 0;
    serve(2, 16'h4242);
    tick();
    chk("err_sticky", {31'd0, timeout_err}, 32'd1);

    // reset in the middle of a transaction (no ack expected)
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_be = 2'b10;
    bus.cpu_addr = 24'h000555; bus.cpu_din = 16'h5555;
    wait_mem_req(n);
    bus.cpu_req = 0;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    rst_checks("rst_mid");
    tick(); tick();
    rst_n = 1'b1;
    tick();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_be = 2'b11;
    bus.cpu_addr = 24'h000666; bus.cpu_din = 16'h6666;
    push(c_ACK_CPU, 16'h0066);
    wait_mem_req(n);
    chk("post_rst_lat", n, 1);
    chk("post_rst_addr", {8'd0, bus.mem_addr}, 32'h000666);
    bus.cpu_req = 0;
    serve(3, 16'h0066);
    chk("post_rst_ack", {31'd0, bus.cpu_ack}, 32'd1);
    tick(); tick();

    // mem_ack lands exactly on the timeout threshold cycle
    bus.vid_req = 1; bus.vid_addr = 24'h000777;
    push(c_ACK_VID, 16'h7777);
    wait_mem_req(n);
    bus.vid_req = 0;
    repeat (64) tick();
    bus.mem_ack = 1; bus.mem_dout = 16'h7777;
    tick();
    bus.mem_ack = 0; bus.mem_dout = '0;
    chk("edge_ack", {31'd0, bus.vid_ack}, 32'd1);
    chk("edge_err", {31'd0, timeout_err}, 32'd0);

    repeat (5) tick();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
